// File: rtl/regfile_arbiter_if.sv
// ============================================================================
// Module   : regfile_arbiter_if
// Purpose  : Core, debug and register-file signals seen by regfile_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_arbiter_if;
   logic       core_we;
   logic [3:0] core_wa;
   logic [7:0] core_wd;
   logic [3:0] core_ra1;
   logic       core_stall;
   logic       dbg_req;
   logic       dbg_wr;
   logic [3:0] dbg_addr;
   logic [7:0] dbg_wd;
   logic       dbg_ack;
   logic [7:0] dbg_rd;
   logic       rf_we3;
   logic [3:0] rf_wa3;
   logic [7:0] rf_wd3;
   logic [3:0] rf_ra1;
   logic [7:0] rf_rd1;

   // Arbiter side
   modport slave (
      input  core_we, core_wa, core_wd, core_ra1,
      input  dbg_req, dbg_wr, dbg_addr, dbg_wd,
      input  rf_rd1,
      output core_stall, dbg_ack, dbg_rd,
      output rf_we3, rf_wa3, rf_wd3, rf_ra1
   );

   // Environment side (core, debug requester, register file)
   modport master (
      output core_we, core_wa, core_wd, core_ra1,
      output dbg_req, dbg_wr, dbg_addr, dbg_wd,
      output rf_rd1,
      input  core_stall, dbg_ack, dbg_rd,
      input  rf_we3, rf_wa3, rf_wd3, rf_ra1
   );
endinterface

`default_nettype wire

// File: rtl/regfile_arbiter.sv
// ============================================================================
// Module   : regfile_arbiter
// Purpose  : Shares the register file write port and read port 1 between the
//            core and a debug requester; debug steals one stalled cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   regfile_arbiter_if.slave   bus
);

   localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_starve_cnt;
   logic [7:0] r_dbg_rd;
   logic       w_grant;
   logic       w_core_stall;
   logic       w_rf_we3;
   logic [3:0] w_rf_wa3;
   logic [7:0] w_rf_wd3;
   logic [3:0] w_rf_ra1;

   // Debug wins when the core leaves the write port free, or has starved it long enough
   assign w_grant = (r_state == IDLE) && bus.dbg_req &&
                    (!bus.core_we || (r_starve_cnt == c_starve_max));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= 3'd0;
         r_dbg_rd     <= 8'h00;
      end else begin
         r_state <= w_state_next;
         if (!bus.dbg_req || w_grant) begin
            r_starve_cnt <= 3'd0;
         end else if ((r_state == IDLE) && bus.core_we && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
         end
         // Read port sees the pre-write contents, so writes return the old value
         if (r_state == ACCESS) begin
            r_dbg_rd <= bus.rf_rd1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_core_stall = 1'b0;
      w_rf_we3     = bus.core_we;
      w_rf_wa3     = bus.core_wa;
      w_rf_wd3     = bus.core_wd;
      w_rf_ra1     = bus.core_ra1;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            w_core_stall = 1'b1;
            w_rf_we3     = bus.dbg_wr;
            w_rf_wa3     = bus.dbg_addr;
            w_rf_wd3     = bus.dbg_wd;
            w_rf_ra1     = bus.dbg_addr;
            w_state_next = DONE;
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      // Reset freezes the core and blocks every write, including a debug one in flight
      if (reset) begin
         w_core_stall = 1'b1;
         w_rf_we3     = 1'b0;
         w_rf_wa3     = bus.core_wa;
         w_rf_wd3     = bus.core_wd;
         w_rf_ra1     = bus.core_ra1;
      end
   end

   assign bus.core_stall = w_core_stall;
   assign bus.rf_we3     = w_rf_we3;
   assign bus.rf_wa3     = w_rf_wa3;
   assign bus.rf_wd3     = w_rf_wd3;
   assign bus.rf_ra1     = w_rf_ra1;
   assign bus.dbg_ack    = (r_state == DONE) && !reset;
   assign bus.dbg_rd     = r_dbg_rd;

endmodule

`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
// ============================================================================
// Module   : tb_regfile_arbiter
// Purpose  : Self-checking bench for regfile_arbiter with a register file model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_arbiter;

   localparam int c_starve = 4;

   logic       clk;
   logic       reset;
   logic [7:0] mem [16];
   int         checks;
   int         errors;

   regfile_arbiter_if bus ();

   regfile_arbiter #(.STARVE_MAX(c_starve)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: R0 reads as zero, writes land on the rising edge
   assign bus.rf_rd1 = (bus.rf_ra1 == 4'd0) ? 8'h00 : mem[bus.rf_ra1];
   always @(posedge clk) begin
      if (bus.rf_we3) mem[bus.rf_wa3] <= bus.rf_wd3;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [3:0] ra;
      logic       e_we;
      logic [3:0] e_wa;
      logic [7:0] e_wd;
      logic [3:0] e_ra;
      logic       e_stall;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic core_write(input logic [3:0] a, input logic [7:0] d);
      bus.core_we = 1'b1;
      bus.core_wa = a;
      bus.core_wd = d;
      tick();
      bus.core_we = 1'b0;
   endtask

   // Core writes every cycle with debug read pending: grant after STARVE_MAX waits
   task automatic starve_seq(input logic [3:0] addr);
      bus.dbg_req  = 1'b1;
      bus.dbg_wr   = 1'b0;
      bus.dbg_addr = addr;
      for (int k = 0; k <= c_starve + 2; k++) begin
         int kk;
         kk = (k > c_starve + 1) ? c_starve + 1 : k;
         bus.core_we = 1'b1;
         bus.core_wa = 4'(kk + 1);
         bus.core_wd = 8'(8'h60 + kk);
         @(negedge clk);
         chk("starve_stall", 32'(bus.core_stall), 32'(k == c_starve + 1));
         chk("starve_ack", 32'(bus.dbg_ack), 32'(k == c_starve + 2));
         chk("starve_we3", 32'(bus.rf_we3), 32'(k != c_starve + 1));
         if (k == c_starve + 2) chk("starve_held_wa", 32'(bus.rf_wa3), 32'(c_starve + 2));
         tick();
      end
      bus.dbg_req = 1'b0;
      bus.core_we = 1'b0;
   endtask

   // Reference model state for the random phase
   logic [7:0] ref_regs [16];
   int         phase;      // 0 free, 1 stolen cycle, 2 acknowledge cycle
   int         waited;
   logic [7:0] exp_rd;
   logic       req_on;
   logic       acked_prev;
   logic       e_stall, e_ack, e_we;
   logic [3:0] e_wa, e_ra;
   logic [7:0] e_wd;
   logic       grant;

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{1'b0, 1'b1, 4'd3, 8'h5A, 4'd2, 1'b1, 4'd3, 8'h5A, 4'd2, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'd0, 1'b0, 4'hF, 8'hFF, 4'd0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 4'd0, 8'h00, 4'hF, 1'b1, 4'd0, 8'h00, 4'hF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 4'd4, 8'hC3, 4'd6, 1'b0, 4'd4, 8'hC3, 4'd6, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 4'hA, 8'h81, 4'd9, 1'b1, 4'hA, 8'h81, 4'd9, 1'b0};

      reset = 1'b1;
      bus.core_we = 1'b0; bus.core_wa = 4'd0; bus.core_wd = 8'h00; bus.core_ra1 = 4'd0;
      bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0; bus.dbg_addr = 4'd0; bus.dbg_wd = 8'h00;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_ack", 32'(bus.dbg_ack), 32'd0);
      chk("reset_rd", 32'(bus.dbg_rd), 32'h00);
      chk("reset_stall", 32'(bus.core_stall), 32'd0);
      tick();

      // Pass-through table (IDLE, no debug request)
      for (int i = 0; i < 5; i++) begin
         reset        = vecs[i].rst;
         bus.core_we  = vecs[i].we;
         bus.core_wa  = vecs[i].wa;
         bus.core_wd  = vecs[i].wd;
         bus.core_ra1 = vecs[i].ra;
         @(negedge clk);
         chk("tbl_we3", 32'(bus.rf_we3), 32'(vecs[i].e_we));
         chk("tbl_wa3", 32'(bus.rf_wa3), 32'(vecs[i].e_wa));
         chk("tbl_wd3", 32'(bus.rf_wd3), 32'(vecs[i].e_wd));
         chk("tbl_ra1", 32'(bus.rf_ra1), 32'(vecs[i].e_ra));
         chk("tbl_stall", 32'(bus.core_stall), 32'(vecs[i].e_stall));
         chk("tbl_ack", 32'(bus.dbg_ack), 32'd0);
         tick();
      end
      reset = 1'b0;
      bus.core_we = 1'b0;

      // Debug read of R5
      core_write(4'd5, 8'h33);
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 4'd5;
      @(negedge clk); chk("rd_idle_stall", 32'(bus.core_stall), 32'd0);
      tick();
      @(negedge clk);
      chk("rd_acc_stall", 32'(bus.core_stall), 32'd1);
      chk("rd_acc_ra1", 32'(bus.rf_ra1), 32'd5);
      chk("rd_acc_we3", 32'(bus.rf_we3), 32'd0);
      tick();
      @(negedge clk);
      chk("rd_ack", 32'(bus.dbg_ack), 32'd1);
      chk("rd_data", 32'(bus.dbg_rd), 32'h33);
      chk("rd_done_stall", 32'(bus.core_stall), 32'd0);
      tick();
      bus.dbg_req = 1'b0;

      // Debug write of R7 returns the old value
      core_write(4'd7, 8'h11);
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 4'd7; bus.dbg_wd = 8'hA5;
      tick();
      @(negedge clk);
      chk("wr_acc_we3", 32'(bus.rf_we3), 32'd1);
      chk("wr_acc_wa3", 32'(bus.rf_wa3), 32'd7);
      chk("wr_acc_wd3", 32'(bus.rf_wd3), 32'hA5);
      tick();
      @(negedge clk);
      chk("wr_ack", 32'(bus.dbg_ack), 32'd1);
      chk("wr_old", 32'(bus.dbg_rd), 32'h11);
      tick();
      bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0;
      bus.core_ra1 = 4'd7;
      @(negedge clk);
      chk("wr_core_read", 32'(bus.rf_rd1), 32'hA5);
      tick();

      starve_seq(4'd2);

      // Reset during the stolen cycle of a debug write
      core_write(4'd9, 8'h44);
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 4'd9; bus.dbg_wd = 8'hEE;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_acc_we3", 32'(bus.rf_we3), 32'd0);
      chk("rst_acc_stall", 32'(bus.core_stall), 32'd1);
      tick();
      reset = 1'b0; bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0;
      @(negedge clk);
      chk("rst_no_ack", 32'(bus.dbg_ack), 32'd0);
      chk("rst_stall", 32'(bus.core_stall), 32'd0);
      chk("rst_mem", 32'(mem[9]), 32'h44);
      chk("rst_rd", 32'(bus.dbg_rd), 32'h00);
      tick();
      starve_seq(4'd9);

      // Request held through ack: second transaction three cycles later
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 4'd5;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("b2b_stall", 32'(bus.core_stall), 32'(k == 1 || k == 4));
         chk("b2b_ack", 32'(bus.dbg_ack), 32'(k == 2 || k == 5));
         tick();
      end
      bus.dbg_req = 1'b0;

      // Randomized run against the reference model
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) ref_regs[i] = mem[i];
      phase = 0; waited = 0; exp_rd = 8'h00; req_on = 1'b0; acked_prev = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (req_on) begin
            if (acked_prev && ($urandom_range(0, 3) != 0)) req_on = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            req_on       = 1'b1;
            bus.dbg_wr   = 1'($urandom_range(0, 1));
            bus.dbg_addr = 4'($urandom_range(0, 15));
            bus.dbg_wd   = 8'($urandom_range(0, 255));
         end
         bus.dbg_req = req_on;
         if (phase != 1) begin
            bus.core_we  = ($urandom_range(0, 3) != 0);
            bus.core_wa  = 4'($urandom_range(0, 15));
            bus.core_wd  = 8'($urandom_range(0, 255));
            bus.core_ra1 = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         e_stall = (phase == 1);
         e_ack   = (phase == 2);
         if (phase == 1) begin
            e_we = bus.dbg_wr; e_wa = bus.dbg_addr; e_wd = bus.dbg_wd; e_ra = bus.dbg_addr;
         end else begin
            e_we = bus.core_we; e_wa = bus.core_wa; e_wd = bus.core_wd; e_ra = bus.core_ra1;
         end
         chk("rnd_stall", 32'(bus.core_stall), 32'(e_stall));
         chk("rnd_ack", 32'(bus.dbg_ack), 32'(e_ack));
         chk("rnd_we3", 32'(bus.rf_we3), 32'(e_we));
         chk("rnd_wa3", 32'(bus.rf_wa3), 32'(e_wa));
         chk("rnd_wd3", 32'(bus.rf_wd3), 32'(e_wd));
         chk("rnd_ra1", 32'(bus.rf_ra1), 32'(e_ra));
         chk("rnd_rd", 32'(bus.dbg_rd), 32'(exp_rd));
         acked_prev = (phase == 2);
         if (phase == 1) begin
            exp_rd = (bus.dbg_addr == 4'd0) ? 8'h00 : ref_regs[bus.dbg_addr];
            if (bus.dbg_wr) ref_regs[bus.dbg_addr] = bus.dbg_wd;
            phase = 2;
         end else begin
            if (bus.core_we) ref_regs[bus.core_wa] = bus.core_wd;
            if (phase == 2) begin
               phase = 0;
               if (!req_on) waited = 0;
            end else begin
               grant = req_on && (!bus.core_we || waited >= c_starve);
               if (grant) begin
                  phase  = 1;
                  waited = 0;
               end else if (req_on) begin
                  waited++;
               end else begin
                  waited = 0;
               end
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the 16×8 register file's write port and its first read port between the CPU core and a debug/IO requester. The core path passes straight through by default. A debug transaction steals exactly one cycle, during which the core is stalled. A starvation counter guarantees debug progress when the core writes every cycle. The block sits between the core datapath (writeback mux, RA1 decode) and the register file.

## Interface
Parameters:
- STARVE_MAX, 4 — consecutive core-won cycles (with debug pending) after which debug is granted unconditionally; legal range 1–7.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- core_we  in  1  core write-back enable
- core_wa  in  4  core write address
- core_wd  in  8  core write data
- core_ra1  in  4  core read address, port 1
- core_stall  out  1  core must hold all state this cycle; its write is not performed
- dbg_req  in  1  debug transaction request, held until dbg_ack
- dbg_wr  in  1  1 = write, 0 = read; stable while dbg_req high
- dbg_addr  in  4  debug register address
- dbg_wd  in  8  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rd  out  8  debug read data, valid when dbg_ack is high; held until the next ack
- rf_we3  out  1  to register file write enable
- rf_wa3  out  4  to register file write address
- rf_wd3  out  8  to register file write data
- rf_ra1  out  4  to register file read address, port 1
- rf_rd1  in  8  from register file read data, port 1

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - Pass-through: rf_we3=core_we, rf_wa3=core_wa, rf_wd3=core_wd, rf_ra1=core_ra1; core_stall=0.
  - Go to ACCESS when dbg_req && (!core_we || starve_cnt==STARVE_MAX); otherwise stay in IDLE.
  - The core write in the granting IDLE cycle is still performed.
- ACCESS:
  - core_stall=1.
  - rf_we3=dbg_wr, rf_wa3=dbg_addr, rf_wd3=dbg_wd, rf_ra1=dbg_addr.
  - dbg_rd is loaded from rf_rd1 at the clock edge ending ACCESS.
  - Always go to DONE.
- DONE:
  - Pass-through as in IDLE; dbg_ack=1.
  - Always go to IDLE.
  - If dbg_req is still high in the following IDLE cycle, it is treated as a new transaction.
- starve_cnt:
  - Width 3 bits.
  - In IDLE with dbg_req && core_we and no grant: increment, saturating at STARVE_MAX.
  - Cleared when entering ACCESS, or in any cycle with dbg_req=0.
- Write transactions return the pre-write register value in dbg_rd. The register file updates at the edge ending ACCESS.
- Address 0: debug writes are forwarded unchanged. Reads of address 0 return 0 (register-file behaviour).

## Timing
- Reset values: state IDLE, starve_cnt 0, dbg_ack 0, dbg_rd 0x00.
- While reset is high: rf_we3 is forced to 0 and core_stall is forced to 1. All other rf_* outputs pass through from the core.
- Reset mid-transaction (in ACCESS or DONE): go to IDLE with no ack. Any write in the reset cycle is suppressed.
- Latency, dbg_req rising to dbg_ack:
  - 2 cycles when core_we=0 at request (IDLE→ACCESS→DONE).
  - At most STARVE_MAX+2 cycles when the core writes every cycle.
- Core stall cost: exactly 1 cycle per debug transaction. No core write is ever lost; the core re-presents it after the stall.
- Back-to-back debug transactions: minimum spacing is 3 cycles (IDLE, ACCESS, DONE). The core gets at least one free cycle (DONE) between any two stalls.
- All outputs other than dbg_rd and dbg_ack are combinational from state and inputs. dbg_ack is decoded from state; dbg_rd is registered.

## Test plan
- Reset, then core_we=1, core_wa=3, core_wd=0x5A → rf_we3=1, rf_wa3=3, rf_wd3=0x5A in the same cycle; core_stall=0; dbg_ack=0; dbg_rd=0x00.
- Debug read of R5=0x33, core_we=0: dbg_req at cycle n → core_stall=1 and rf_ra1=5 at n+1; dbg_ack=1, dbg_rd=0x33 at n+2; core_stall=0 at n+2.
- Debug write, dbg_addr=7, dbg_wd=0xA5, R7=0x11 → rf_we3=1, rf_wa3=7 in ACCESS; dbg_rd=0x11 at ack; a later core read of R7 returns 0xA5.
- core_we=1 every cycle, dbg_req held, STARVE_MAX=4 → core writes in cycles n..n+4; ACCESS at n+5 with core_stall=1; ack at n+6; the core's held write is performed at n+6.
- Reset asserted during ACCESS of a debug write → rf_we3=0, no dbg_ack, target register unchanged, state IDLE, starve_cnt 0.
- dbg_req held high through ack → a second ACCESS starts 3 cycles after the first; the core is unstalled in the intervening DONE cycle.
